hall_call_dispatcher: RTL and testbench

- Collects car-button and hall-button (up/down) presses for an 8-floor car.
- Latches them as pending calls and drives the hall/car lamps.
- Feeds the calls one at a time into the car controller's `valid_in`/`req_floor`/`direction` request port, using round-robin arbitration and rate limiting.
- Sits between the button I/O and the car controller, and uses the car's `current_floor` and door status to retire served calls.

---
 rtl/hall_call_dispatcher_pkg.sv | 44 ++++
 rtl/hall_call_dispatcher_if.sv | 22 ++
 rtl/hall_call_dispatcher_rr_arbiter.sv | 29 ++
 rtl/hall_call_dispatcher.sv | 187 ++++++++++++++++++
 tb/tb_hall_call_dispatcher.sv | 283 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hall_call_dispatcher_pkg.sv
// Shared types and constants for the hall/car call dispatcher.
// Source indices: car calls, then hall-up calls, then hall-down calls.
package elevator_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        GAP,
        HOLD
    } dispatch_state_t;

    typedef enum logic [1:0] {
        SK_CAR = 2'd0,
        SK_UP  = 2'd1,
        SK_DN  = 2'd2
    } src_kind_t;

    localparam int NUM_FLOORS = 8;
    localparam int NUM_SRC    = 24;
    localparam int FLOOR_W    = 3;
    localparam int SRC_W      = 5;

    localparam int SRC_CAR = 0;
    localparam int SRC_UP  = 8;
    localparam int SRC_DN  = 16;

    // Up at the top floor and down at the ground floor cannot exist
    localparam logic [NUM_SRC-1:0] SRC_MASK =
        ~((NUM_SRC'(1) << (SRC_UP + NUM_FLOORS - 1)) |
          (NUM_SRC'(1) << SRC_DN));

    function automatic logic [FLOOR_W-1:0] src_floor(
        input logic [SRC_W-1:0] s
    );
        return FLOOR_W'(int'(s) % NUM_FLOORS);
    endfunction

    function automatic src_kind_t src_kind(
        input logic [SRC_W-1:0] s
    );
        return src_kind_t'(2'(int'(s) / NUM_FLOORS));
    endfunction

endpackage

// File: rtl/hall_call_dispatcher_if.sv
// Request port from the dispatcher into the car controller.
// The dispatcher drives it (master); the car consumes it (slave).
interface hall_call_dispatcher_if;
    import elevator_pkg::*;

    logic               valid_out;
    logic [FLOOR_W-1:0] req_floor_out;
    logic               direction_out;

    modport master (
        output valid_out,
        output req_floor_out,
        output direction_out
    );

    modport slave (
        input valid_out,
        input req_floor_out,
        input direction_out
    );

endinterface

// File: rtl/hall_call_dispatcher_rr_arbiter.sv
// Combinational round-robin picker: first set request after last grant.
// Search wraps from index N-1 back to 0.
module rr_arbiter #(
    parameter int N = 24,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] i_req,
    input  logic [W-1:0] i_last_grant,
    output logic [W-1:0] o_grant,
    output logic         o_grant_valid
);

    logic [W-1:0] w_idx;

    // Descending scan so the smallest offset is the final winner
    always_comb begin
        w_idx         = '0;
        o_grant       = '0;
        o_grant_valid = 1'b0;
        for (int i = N; i >= 1; i--) begin
            w_idx = W'((int'(i_last_grant) + i) % N);
            if (i_req[w_idx]) begin
                o_grant       = w_idx;
                o_grant_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/hall_call_dispatcher.sv
// Latches button presses as pending calls and feeds them to the car
// one at a time with round-robin arbitration and rate limiting.
module hall_call_dispatcher
    import elevator_pkg::*;
#(
    parameter int ISSUE_GAP      = 4,
    parameter int REISSUE_CYCLES = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_FLOORS-1:0] car_btn,
    input  logic [NUM_FLOORS-1:0] hall_up_btn,
    input  logic [NUM_FLOORS-1:0] hall_dn_btn,
    input  logic [FLOOR_W-1:0]    current_floor,
    input  logic                  door_open,
    input  logic                  emergency,
    hall_call_dispatcher_if.master req,
    output logic [NUM_FLOORS-1:0] car_lamp,
    output logic [NUM_FLOORS-1:0] up_lamp,
    output logic [NUM_FLOORS-1:0] dn_lamp,
    output logic                  busy
);

    localparam int GAP_W = (ISSUE_GAP > 1) ? $clog2(ISSUE_GAP) : 1;
    localparam int TMR_W = $clog2(REISSUE_CYCLES);

    dispatch_state_t r_state;
    dispatch_state_t w_state_nxt;

    logic [NUM_SRC-1:0]    w_btn;
    logic [NUM_SRC-1:0]    r_btn_q;
    logic [NUM_SRC-1:0]    w_set;
    logic [NUM_SRC-1:0]    w_clr;
    logic [NUM_SRC-1:0]    w_elig;
    logic [NUM_SRC-1:0]    w_grant_oh;
    logic [NUM_SRC-1:0]    r_pending;
    logic [NUM_SRC-1:0]    w_pending_nxt;
    logic [NUM_SRC-1:0]    r_issued;
    logic [NUM_SRC-1:0]    w_issued_nxt;
    logic [NUM_FLOORS-1:0] w_floor_oh;
    logic [SRC_W-1:0]      w_grant;
    logic [SRC_W-1:0]      r_last_grant;
    logic                  w_grant_valid;
    logic [GAP_W-1:0]      r_gap_cnt;
    logic [TMR_W-1:0]      r_tmr;
    logic                  r_door_q;
    logic                  w_door_rise;
    logic                  w_tmr_fire;
    logic                  w_issue;
    logic                  w_hold_exit;
    logic                  w_clear_all;
    logic                  w_dir;
    logic                  r_valid;
    logic                  r_dir;
    logic                  r_busy;
    logic [FLOOR_W-1:0]    r_req_floor;

    always_comb begin
        w_btn = '0;
        w_btn[SRC_CAR +: NUM_FLOORS] = car_btn;
        w_btn[SRC_UP  +: NUM_FLOORS] = hall_up_btn;
        w_btn[SRC_DN  +: NUM_FLOORS] = hall_dn_btn;
    end

    assign w_set      = w_btn & ~r_btn_q & SRC_MASK;
    assign w_floor_oh = {{(NUM_FLOORS-1){1'b0}}, 1'b1} << current_floor;
    assign w_clr      = door_open ? {3{w_floor_oh}} : '0;
    assign w_elig     = r_pending & ~r_issued;

    rr_arbiter #(
        .N (NUM_SRC),
        .W (SRC_W)
    ) u_arb (
        .i_req         (w_elig),
        .i_last_grant  (r_last_grant),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) r_state <= IDLE;
        else        r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE: begin
                if (emergency)          w_state_nxt = HOLD;
                else if (w_grant_valid) w_state_nxt = ISSUE;
            end
            ISSUE: w_state_nxt = GAP;
            GAP: begin
                if (emergency)
                    w_state_nxt = HOLD;
                else if (r_gap_cnt == GAP_W'(ISSUE_GAP - 1))
                    w_state_nxt = IDLE;
            end
            HOLD: begin
                if (!emergency) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_comb begin
        w_issue     = (r_state == IDLE) && (w_state_nxt == ISSUE);
        w_hold_exit = (r_state == HOLD) && !emergency;
        w_door_rise = door_open && !r_door_q;
        w_tmr_fire  = r_busy && !w_door_rise &&
                      (r_tmr == TMR_W'(REISSUE_CYCLES - 1));
        w_clear_all = w_hold_exit || w_tmr_fire;
        w_grant_oh  = w_issue ? (NUM_SRC'(1) << w_grant) : '0;
    end

    always_comb begin
        w_dir = 1'b0;
        unique case (1'b1)
            (src_kind(w_grant) == SK_CAR):
                w_dir = (src_floor(w_grant) > current_floor);
            (src_kind(w_grant) == SK_UP):
                w_dir = 1'b1;
            default:
                w_dir = 1'b0;
        endcase
    end

    // Service clear overrides both a same-cycle press and a same-cycle grant
    assign w_pending_nxt = (r_pending | w_set) & ~w_clr;
    assign w_issued_nxt  = ((w_clear_all ? '0 : r_issued) | w_grant_oh)
                           & ~w_clr & w_pending_nxt;

    // Button history resets high: a button held across reset is not an edge
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_btn_q      <= '1;
            r_pending    <= '0;
            r_issued     <= '0;
            r_last_grant <= SRC_W'(NUM_SRC - 1);
            r_door_q     <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            r_btn_q   <= w_btn;
            r_pending <= w_pending_nxt;
            r_issued  <= w_issued_nxt;
            r_door_q  <= door_open;
            r_busy    <= |w_pending_nxt;
            if (w_issue) r_last_grant <= w_grant;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_gap_cnt <= '0;
            r_tmr     <= '0;
        end else begin
            if (r_state == GAP) r_gap_cnt <= r_gap_cnt + 1'b1;
            else                r_gap_cnt <= '0;
            if (!r_busy || w_door_rise || w_tmr_fire) r_tmr <= '0;
            else                                      r_tmr <= r_tmr + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid     <= 1'b0;
            r_req_floor <= '0;
            r_dir       <= 1'b0;
        end else begin
            r_valid <= w_issue;
            if (w_issue) begin
                r_req_floor <= src_floor(w_grant);
                r_dir       <= w_dir;
            end
        end
    end

    assign req.valid_out     = r_valid;
    assign req.req_floor_out = r_req_floor;
    assign req.direction_out = r_dir;

    assign car_lamp = r_pending[SRC_CAR +: NUM_FLOORS];
    assign up_lamp  = r_pending[SRC_UP  +: NUM_FLOORS];
    assign dn_lamp  = r_pending[SRC_DN  +: NUM_FLOORS];
    assign busy     = r_busy;

endmodule

// File: tb/tb_hall_call_dispatcher.sv
// Scoreboard bench for hall_call_dispatcher: stimulus pushes expected
// requests, a monitor pops and compares on every valid_out.
module tb_hall_call_dispatcher;

    typedef struct {
        int floor;
        int dir;
        int cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] car_btn = '0;
    logic [7:0] hall_up_btn = '0;
    logic [7:0] hall_dn_btn = '0;
    logic [2:0] current_floor = '0;
    logic       door_open = 1'b0;
    logic       emergency = 1'b0;
    logic [7:0] car_lamp;
    logic [7:0] up_lamp;
    logic [7:0] dn_lamp;
    logic       busy;

    int   checks = 0;
    int   failures = 0;
    int   cyc = 0;
    exp_t sb[$];

    hall_call_dispatcher_if req_if ();

    hall_call_dispatcher dut (
        .clk           (clk),
        .reset         (reset),
        .car_btn       (car_btn),
        .hall_up_btn   (hall_up_btn),
        .hall_dn_btn   (hall_dn_btn),
        .current_floor (current_floor),
        .door_open     (door_open),
        .emergency     (emergency),
        .req           (req_if),
        .car_lamp      (car_lamp),
        .up_lamp       (up_lamp),
        .dn_lamp       (dn_lamp),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int f, input int d, input int c);
        exp_t e;
        e.floor = f;
        e.dir   = d;
        e.cyc   = c;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        car_btn     = '0;
        hall_up_btn = '0;
        hall_dn_btn = '0;
        door_open   = 1'b0;
        emergency   = 1'b0;
        reset       = 1'b0;
        step(2);
        reset = 1'b1;
        step(1);
    endtask

    task automatic service(input int f);
        current_floor = 3'(f);
        door_open     = 1'b1;
        step(1);
        door_open = 1'b0;
        step(1);
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (req_if.valid_out === 1'b1) begin
                if (sb.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_issue: floor %0d at cycle %0d, none expected",
                             req_if.req_floor_out, cyc);
                end else begin
                    e = sb.pop_front();
                    chk("issue_floor", 32'(req_if.req_floor_out), e.floor);
                    chk("issue_dir", 32'(req_if.direction_out), e.dir);
                    chk("issue_cycle", cyc, e.cyc);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int k;
        int r;
        step(1);
        chk("rst_car_lamp", car_lamp, 0);
        chk("rst_up_lamp", up_lamp, 0);
        chk("rst_dn_lamp", dn_lamp, 0);
        chk("rst_busy", busy, 0);
        chk("rst_valid", req_if.valid_out, 0);
        chk("rst_floor", req_if.req_floor_out, 0);
        chk("rst_dir", req_if.direction_out, 0);
        reset = 1'b1;
        step(1);

        // single car call
        current_floor = 3'd0;
        k = cyc;
        car_btn = 8'h20;
        push(5, 1, k + 2);
        step(1);
        chk("t1_car_lamp", car_lamp, 8'h20);
        chk("t1_busy", busy, 1);
        car_btn = '0;
        step(20);
        chk("t1_still_pending", car_lamp, 8'h20);
        service(5);
        chk("t1_served_lamp", car_lamp, 0);
        chk("t1_served_busy", busy, 0);

        // round-robin order and spacing
        do_reset();
        current_floor = 3'd3;
        k = cyc;
        hall_up_btn = 8'h04;
        hall_dn_btn = 8'h40;
        car_btn     = 8'h02;
        push(1, 0, k + 2);
        push(2, 1, k + 8);
        push(6, 0, k + 14);
        step(1);
        chk("t2_car_lamp", car_lamp, 8'h02);
        chk("t2_up_lamp", up_lamp, 8'h04);
        chk("t2_dn_lamp", dn_lamp, 8'h40);
        car_btn     = '0;
        hall_up_btn = '0;
        hall_dn_btn = '0;
        step(20);
        service(1);
        service(2);
        service(6);
        chk("t2_busy_clear", busy, 0);

        // service clear beats a same-cycle press
        do_reset();
        current_floor = 3'd0;
        k = cyc;
        car_btn     = 8'h10;
        hall_up_btn = 8'h10;
        push(4, 1, k + 2);
        push(4, 1, k + 8);
        step(1);
        chk("t3_car_lamp", car_lamp, 8'h10);
        chk("t3_up_lamp", up_lamp, 8'h10);
        car_btn     = '0;
        hall_up_btn = '0;
        step(12);
        current_floor = 3'd4;
        door_open     = 1'b1;
        hall_up_btn   = 8'h10;
        step(1);
        chk("t3_car_cleared", car_lamp, 0);
        chk("t3_up_cleared", up_lamp, 0);
        chk("t3_busy", busy, 0);
        door_open = 1'b0;
        step(1);
        chk("t3_up_held", up_lamp, 0);
        hall_up_btn = '0;
        step(2);
        chk("t3_up_after", up_lamp, 0);

        // masked sources and a button held through service
        do_reset();
        hall_up_btn = 8'h80;
        hall_dn_btn = 8'h01;
        step(1);
        chk("t4_up_masked", up_lamp, 0);
        chk("t4_dn_masked", dn_lamp, 0);
        chk("t4_busy_masked", busy, 0);
        hall_up_btn = '0;
        hall_dn_btn = '0;
        step(10);
        current_floor = 3'd0;
        k = cyc;
        car_btn = 8'h04;
        push(2, 1, k + 2);
        step(5);
        current_floor = 3'd2;
        door_open     = 1'b1;
        step(1);
        chk("t4_held_served", car_lamp, 0);
        door_open = 1'b0;
        step(10);
        chk("t4_held_no_relatch", car_lamp, 0);
        chk("t4_held_busy", busy, 0);
        car_btn = '0;
        step(2);

        // emergency hold, release, then timed re-issue
        do_reset();
        current_floor = 3'd0;
        k = cyc;
        emergency   = 1'b1;
        car_btn     = 8'h08;
        hall_up_btn = 8'h20;
        hall_dn_btn = 8'h40;
        step(1);
        car_btn     = '0;
        hall_up_btn = '0;
        hall_dn_btn = '0;
        step(20);
        chk("t5_hold_car", car_lamp, 8'h08);
        chk("t5_hold_up", up_lamp, 8'h20);
        chk("t5_hold_dn", dn_lamp, 8'h40);
        chk("t5_hold_busy", busy, 1);
        r = cyc;
        emergency = 1'b0;
        push(3, 1, r + 2);
        push(5, 1, r + 8);
        push(6, 0, r + 14);
        push(3, 1, k + 1002);
        push(5, 1, k + 1008);
        push(6, 0, k + 1014);
        while (cyc < k + 1020) step(1);
        chk("t5_after_car", car_lamp, 8'h08);
        chk("t5_after_busy", busy, 1);

        // asynchronous reset in GAP
        do_reset();
        current_floor = 3'd0;
        k = cyc;
        car_btn = 8'h80;
        push(7, 1, k + 2);
        step(1);
        car_btn = '0;
        step(2);
        chk("t6_pre_floor", req_if.req_floor_out, 7);
        #2 reset = 1'b0;
        #1;
        chk("t6_valid", req_if.valid_out, 0);
        chk("t6_floor", req_if.req_floor_out, 0);
        chk("t6_dir", req_if.direction_out, 0);
        chk("t6_car_lamp", car_lamp, 0);
        chk("t6_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;
        step(30);
        chk("t6_post_busy", busy, 0);
        chk("t6_post_lamp", car_lamp, 0);

        step(5);
        chk("sb_drained", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
